// File: rtl/pc_stack_ext.sv
// Program counter with circular return-address stack and staged jump target
// for the nibble-serial CPU family.
module pc_stack_ext #(
    parameter int ADDR_WIDTH = 12,
    parameter int WORD_WIDTH = 4,
    parameter int DEPTH      = 7,
    localparam int NW        = ADDR_WIDTH / WORD_WIDTH,
    localparam int DW        = $clog2(DEPTH + 1)
) (
    input  logic                  clock,
    input  logic                  reset_n,
    input  logic                  halt,
    input  logic [2:0]            cycle,
    input  logic [1:0]            control,
    input  logic [1:0]            pc_next_sel,
    input  logic [NW-1:0]         pc_write_enable,
    input  logic [WORD_WIDTH-1:0] data,
    input  logic [WORD_WIDTH-1:0] regval,
    input  logic [WORD_WIDTH-1:0] inst_operand,
    input  logic                  clear_flags,
    output logic [ADDR_WIDTH-1:0] pc,
    output logic                  pc_enable,
    output logic [WORD_WIDTH-1:0] pc_word,
    output logic [DW-1:0]         depth,
    output logic                  overflow,
    output logic                  underflow
);

    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [2:0] NW3 = 3'(NW);
    localparam logic [PW-1:0] PTR_LAST = PW'(DEPTH - 1);
    localparam logic [DW-1:0] DEPTH_FULL = DW'(DEPTH);

    typedef logic [ADDR_WIDTH-1:0] addr_t;

    addr_t             pc_q, pc_d;
    addr_t             tgt_q, tgt_d;
    addr_t             pc_inc;
    addr_t             stack_q [DEPTH];
    logic [PW-1:0]     ptr_q, ptr_d, ptr_inc, ptr_dec;
    logic [DW-1:0]     depth_q, depth_d;
    logic              ovf_q, ovf_d, unf_q, unf_d;
    logic              commit, push, set_ovf, set_unf, clr;
    logic              full, empty;
    logic [WORD_WIDTH-1:0] src;

    // Address-cycle bus drive: one PC nibble per cycle, LSB first
    always_comb begin
        pc_enable = (cycle < NW3);
        pc_word   = '0;
        for (int i = 0; i < NW; i++) begin
            if (cycle == 3'(i)) pc_word = pc_q[i*WORD_WIDTH +: WORD_WIDTH];
        end
    end

    always_comb begin
        case (pc_next_sel)
            2'b00:   src = data;
            2'b01:   src = inst_operand;
            2'b10:   src = regval;
            default: src = '0;
        endcase
    end

    assign commit  = !halt && (cycle == 3'd7);
    assign clr     = !halt && clear_flags;
    assign pc_inc  = pc_q + addr_t'(1);
    assign ptr_inc = (ptr_q == PTR_LAST) ? '0 : ptr_q + PW'(1);
    assign ptr_dec = (ptr_q == '0) ? PTR_LAST : ptr_q - PW'(1);
    assign full    = (depth_q == DEPTH_FULL);
    assign empty   = (depth_q == '0);

    always_comb begin
        pc_d    = pc_q;
        tgt_d   = tgt_q;
        ptr_d   = ptr_q;
        depth_d = depth_q;
        push    = 1'b0;
        set_ovf = 1'b0;
        set_unf = 1'b0;
        if (commit) begin
            case (control)
                2'b00: pc_d = pc_inc;
                2'b11: pc_d = tgt_q;
                2'b01: begin
                    push  = 1'b1;
                    ptr_d = ptr_inc;
                    pc_d  = tgt_q;
                    if (!full) depth_d = depth_q + DW'(1);
                    else       set_ovf = 1'b1;
                end
                default: begin
                    // An empty pop still loads the stale slot
                    ptr_d = ptr_dec;
                    pc_d  = stack_q[ptr_dec];
                    if (!empty) depth_d = depth_q - DW'(1);
                    else        set_unf = 1'b1;
                end
            endcase
            tgt_d = pc_d;
        end else if (!halt) begin
            for (int i = 0; i < NW; i++) begin
                if (pc_write_enable[i]) tgt_d[i*WORD_WIDTH +: WORD_WIDTH] = src;
            end
        end
    end

    // Set wins over a simultaneous clear
    assign ovf_d = (clr ? 1'b0 : ovf_q) | set_ovf;
    assign unf_d = (clr ? 1'b0 : unf_q) | set_unf;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            pc_q    <= '0;
            tgt_q   <= '0;
            ptr_q   <= '0;
            depth_q <= '0;
            ovf_q   <= 1'b0;
            unf_q   <= 1'b0;
            for (int i = 0; i < DEPTH; i++) stack_q[i] <= '0;
        end else begin
            pc_q    <= pc_d;
            tgt_q   <= tgt_d;
            ptr_q   <= ptr_d;
            depth_q <= depth_d;
            ovf_q   <= ovf_d;
            unf_q   <= unf_d;
            if (push) stack_q[ptr_q] <= pc_inc;
        end
    end

    assign pc        = pc_q;
    assign depth     = depth_q;
    assign overflow  = ovf_q;
    assign underflow = unf_q;

endmodule

// File: tb/tb_pc_stack_ext.sv
// Directed bench for pc_stack_ext: default 12/4/7 instance plus a
// 16-bit, single-entry instance sharing the same stimulus.
module tb_pc_stack_ext;

    logic        clock = 1'b0;
    logic        reset_n, halt, clear_flags;
    logic [2:0]  cycle;
    logic [1:0]  control, pc_next_sel;
    logic [3:0]  we;
    logic [3:0]  data, regval, inst_operand;

    logic [11:0] pc;
    logic        pc_enable;
    logic [3:0]  pc_word;
    logic [2:0]  depth;
    logic        overflow, underflow;

    logic [15:0] w_pc;
    logic        w_pc_enable;
    logic [3:0]  w_pc_word;
    logic [0:0]  w_depth;
    logic        w_overflow, w_underflow;

    int          checks = 0;
    int          failures = 0;
    logic [3:0]  sbq [$];
    logic [11:0] exp_pc;

    pc_stack_ext dut (
        .clock(clock), .reset_n(reset_n), .halt(halt), .cycle(cycle),
        .control(control), .pc_next_sel(pc_next_sel),
        .pc_write_enable(we[2:0]), .data(data), .regval(regval),
        .inst_operand(inst_operand), .clear_flags(clear_flags),
        .pc(pc), .pc_enable(pc_enable), .pc_word(pc_word), .depth(depth),
        .overflow(overflow), .underflow(underflow)
    );

    pc_stack_ext #(.ADDR_WIDTH(16), .WORD_WIDTH(4), .DEPTH(1)) u_wide (
        .clock(clock), .reset_n(reset_n), .halt(halt), .cycle(cycle),
        .control(control), .pc_next_sel(pc_next_sel),
        .pc_write_enable(we), .data(data), .regval(regval),
        .inst_operand(inst_operand), .clear_flags(clear_flags),
        .pc(w_pc), .pc_enable(w_pc_enable), .pc_word(w_pc_word),
        .depth(w_depth), .overflow(w_overflow), .underflow(w_underflow)
    );

    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic idle();
        cycle = 3'd0; control = 2'b00; we = 4'b0; halt = 1'b0;
        clear_flags = 1'b0; pc_next_sel = 2'b00;
        data = 4'h0; regval = 4'h0; inst_operand = 4'h0;
    endtask

    task automatic do_reset();
        idle();
        reset_n = 1'b0;
        #1;
        @(negedge clock);
        reset_n = 1'b1;
        sbq.delete();
        exp_pc = 12'h000;
    endtask

    // One 8-cycle instruction; staging nibble i is written in cycle 3+i
    task automatic instr(input logic [1:0] ctl, input logic [15:0] tgt,
                         input logic [3:0] wm, input logic [1:0] sel,
                         input logic [11:0] exp_after,
                         input bit clr7, input bit halt7);
        logic [3:0] nib, got;
        for (int i = 0; i < 3; i++) begin
            nib = exp_pc[i*4 +: 4];
            sbq.push_back(nib);
        end
        for (int c = 0; c < 8; c++) begin
            cycle = 3'(c);
            control = ctl;
            pc_next_sel = sel;
            we = 4'b0;
            nib = 4'h0;
            if (c >= 3 && c <= 6) begin
                we  = wm & 4'(4'b1 << (c - 3));
                nib = tgt[(c-3)*4 +: 4];
            end
            data         = (sel == 2'b00) ? nib : ~nib;
            inst_operand = (sel == 2'b01) ? nib : ~nib;
            regval       = (sel == 2'b10) ? nib : ~nib;
            clear_flags  = clr7 && (c == 7);
            halt         = halt7 && (c == 7);
            #1;
            check("pc_enable", 32'(pc_enable), 32'(c < 3));
            if (c < 3) begin
                if (sbq.size() == 0) begin
                    failures++;
                    $error("FAIL sb_underrun observed=empty expected=nibble");
                end else begin
                    got = sbq.pop_front();
                    check("pc_word", 32'(pc_word), 32'(got));
                end
            end
            @(posedge clock);
            @(negedge clock);
            if (c == 7 && halt7) begin
                check("halt_pc", 32'(pc), 32'(exp_pc));
                halt = 1'b0;
                @(posedge clock);
                @(negedge clock);
            end
        end
        idle();
        exp_pc = exp_after;
        check("pc", 32'(pc), 32'(exp_after));
    endtask

    initial begin
        idle();
        reset_n = 1'b0;
        exp_pc = 12'h000;
        #1;
        check("rst_pc", 32'(pc), 0);
        check("rst_depth", 32'(depth), 0);
        check("rst_ovf", 32'(overflow), 0);
        check("rst_unf", 32'(underflow), 0);
        check("rst_bus_en", 32'(pc_enable), 1);
        @(negedge clock);
        reset_n = 1'b1;

        // Sequential fetch
        instr(2'b00, 16'h0, 4'b0, 2'b00, 12'h001, 0, 0);
        instr(2'b00, 16'h0, 4'b0, 2'b00, 12'h002, 0, 0);
        instr(2'b00, 16'h0, 4'b0, 2'b00, 12'h003, 0, 0);

        // Jump via operand, call, return
        instr(2'b11, 16'h0122, 4'b0111, 2'b01, 12'h122, 0, 0);
        instr(2'b01, 16'h0456, 4'b0111, 2'b00, 12'h456, 0, 0);
        check("call_depth", 32'(depth), 1);
        instr(2'b10, 16'h0, 4'b0, 2'b00, 12'h123, 0, 0);
        check("ret_depth", 32'(depth), 0);

        // Partial staging keeps upper nibbles; regval and zero sources
        instr(2'b11, 16'h0007, 4'b0001, 2'b10, 12'h127, 0, 0);
        instr(2'b11, 16'h0000, 4'b0010, 2'b11, 12'h107, 0, 0);

        // Eight calls into a 7-deep stack
        for (int k = 1; k <= 8; k++)
            instr(2'b01, 16'(16'h200 + k), 4'b0111, 2'b00,
                  12'(12'h200 + k), 0, 0);
        check("ovf_depth", 32'(depth), 7);
        check("ovf_flag", 32'(overflow), 1);
        for (int k = 8; k >= 2; k--)
            instr(2'b10, 16'h0, 4'b0, 2'b00, 12'(12'h200 + k), 0, 0);
        check("pop_depth", 32'(depth), 0);
        check("pop_unf0", 32'(underflow), 0);
        instr(2'b10, 16'h0, 4'b0, 2'b00, 12'h208, 0, 0);
        check("pop_unf1", 32'(underflow), 1);
        check("pop_depth0", 32'(depth), 0);
        clear_flags = 1'b1;
        @(posedge clock);
        @(negedge clock);
        clear_flags = 1'b0;
        check("clr_ovf", 32'(overflow), 0);
        check("clr_unf", 32'(underflow), 0);

        // Empty returns from reset; set beats clear
        do_reset();
        instr(2'b10, 16'h0, 4'b0, 2'b00, 12'h000, 0, 0);
        check("empty_unf", 32'(underflow), 1);
        check("empty_depth", 32'(depth), 0);
        instr(2'b10, 16'h0, 4'b0, 2'b00, 12'h000, 1, 0);
        check("setwins_unf", 32'(underflow), 1);

        // Halt through commit cycle
        instr(2'b01, 16'h03A5, 4'b0111, 2'b00, 12'h3A5, 0, 1);
        check("halt_depth", 32'(depth), 1);
        instr(2'b10, 16'h0, 4'b0, 2'b00, 12'h001, 0, 0);
        check("halt_ret_depth", 32'(depth), 0);

        // Async reset mid-instruction after staging nibble 0
        for (int c = 0; c < 4; c++) begin
            cycle = 3'(c);
            we = (c == 3) ? 4'b0001 : 4'b0000;
            data = 4'hF;
            @(posedge clock);
            @(negedge clock);
        end
        cycle = 3'd4;
        we = 4'b0;
        reset_n = 1'b0;
        #1;
        check("mid_rst_pc", 32'(pc), 0);
        check("mid_rst_unf", 32'(underflow), 0);
        check("mid_rst_depth", 32'(depth), 0);
        @(negedge clock);
        reset_n = 1'b1;
        idle();
        sbq.delete();
        exp_pc = 12'h000;
        instr(2'b11, 16'h0, 4'b0, 2'b00, 12'h000, 0, 0);

        // 16-bit, depth-1 instance: wrap and single-slot overflow
        instr(2'b11, 16'hFFFF, 4'b1111, 2'b00, 12'hFFF, 0, 0);
        check("w_jump", 32'(w_pc), 32'hFFFF);
        instr(2'b00, 16'h0, 4'b0, 2'b00, 12'h000, 0, 0);
        check("w_wrap", 32'(w_pc), 0);
        instr(2'b11, 16'hFFFF, 4'b1111, 2'b00, 12'hFFF, 0, 0);
        instr(2'b01, 16'h1234, 4'b1111, 2'b00, 12'h234, 0, 0);
        check("w_call_pc", 32'(w_pc), 32'h1234);
        check("w_call_depth", 32'(w_depth), 1);
        instr(2'b01, 16'h0ABC, 4'b1111, 2'b00, 12'hABC, 0, 0);
        check("w_ovf", 32'(w_overflow), 1);
        check("w_ovf_depth", 32'(w_depth), 1);
        check("main_depth2", 32'(depth), 2);
        instr(2'b10, 16'h0, 4'b0, 2'b00, 12'h235, 0, 0);
        check("w_ret_pc", 32'(w_pc), 32'h1235);
        check("w_ret_depth", 32'(w_depth), 0);
        instr(2'b10, 16'h0, 4'b0, 2'b00, 12'h000, 0, 0);
        check("w_unf", 32'(w_underflow), 1);
        check("w_stale_pc", 32'(w_pc), 32'h1235);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
